// File: rtl/ex_result_stage_if.sv
// Handshake bundle for ex_result_stage: ALU-side entry inputs, EX/MEM output
// entry and the PC redirect. The block is the slave; its environment is the master.
interface ex_result_stage_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) ();
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic [RD_W-1:0] rd_i;
  logic            rd_we_i;
  logic [1:0]      kind_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_data_o;
  logic [RD_W-1:0] out_rd_o;
  logic            out_we_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            misalign_o;

  modport slave (
    input  in_valid_i, alu_result_i, pc_i, imm_i, rd_i, rd_we_i, kind_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_rd_o, out_we_o,
           redirect_valid_o, redirect_pc_o, misalign_o
  );

  modport master (
    output in_valid_i, alu_result_i, pc_i, imm_i, rd_i, rd_we_i, kind_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_rd_o, out_we_o,
           redirect_valid_o, redirect_pc_o, misalign_o
  );
endinterface

// File: rtl/ex_result_stage.sv
// EX/MEM pipeline register: forms the write-back entry, resolves branches/jumps
// into a one-cycle redirect, and feeds downstream through a two-entry skid buffer.
module ex_result_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ex_result_stage_if.slave  bus
);

  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JUMP   = 2'b10;

  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_data;
  logic            w_we;
  logic            w_accept;
  logic            w_drain;

  logic            r_m_valid, r_s_valid;
  logic [XLEN-1:0] r_m_data, r_s_data;
  logic [RD_W-1:0] r_m_rd, r_s_rd;
  logic            r_m_we, r_s_we;
  logic            r_redir_valid;
  logic [XLEN-1:0] r_redir_pc;
  logic            r_misalign;

  logic            w_m_valid_nx, w_s_valid_nx;
  logic [XLEN-1:0] w_m_data_nx, w_s_data_nx;
  logic [RD_W-1:0] w_m_rd_nx, w_s_rd_nx;
  logic            w_m_we_nx, w_s_we_nx;

  assign w_accept = bus.in_valid_i & ~r_s_valid;
  assign w_drain  = r_m_valid & bus.out_ready_i;

  // Entry formation from the current upstream instruction (kind 11 behaves as ALU).
  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    w_data   = bus.alu_result_i;
    w_we     = bus.rd_we_i & (bus.rd_i != {RD_W{1'b0}});
    case (bus.kind_i)
      KIND_BRANCH: begin
        w_taken  = bus.alu_result_i[0];
        w_target = bus.pc_i + bus.imm_i;
        w_data   = '0;
        w_we     = 1'b0;
      end
      KIND_JUMP: begin
        w_taken  = 1'b1;
        w_target = bus.alu_result_i & ~XLEN'(1);
        w_data   = bus.pc_i + XLEN'(4);
      end
      default: begin
        w_taken  = 1'b0;
      end
    endcase
  end

  // Skid-buffer next state; S is only ever loaded while M holds and is not draining.
  always_comb begin
    w_m_valid_nx = r_m_valid;
    w_m_data_nx  = r_m_data;
    w_m_rd_nx    = r_m_rd;
    w_m_we_nx    = r_m_we;
    w_s_valid_nx = r_s_valid;
    w_s_data_nx  = r_s_data;
    w_s_rd_nx    = r_s_rd;
    w_s_we_nx    = r_s_we;
    if (r_s_valid) begin
      if (w_drain) begin
        w_m_data_nx  = r_s_data;
        w_m_rd_nx    = r_s_rd;
        w_m_we_nx    = r_s_we;
        w_s_valid_nx = 1'b0;
      end else begin
        w_s_valid_nx = 1'b1;
      end
    end else if (w_accept) begin
      if (!r_m_valid || w_drain) begin
        w_m_valid_nx = 1'b1;
        w_m_data_nx  = w_data;
        w_m_rd_nx    = bus.rd_i;
        w_m_we_nx    = w_we;
      end else begin
        w_s_valid_nx = 1'b1;
        w_s_data_nx  = w_data;
        w_s_rd_nx    = bus.rd_i;
        w_s_we_nx    = w_we;
      end
    end else if (w_drain) begin
      w_m_valid_nx = 1'b0;
    end else begin
      w_m_valid_nx = r_m_valid;
    end
  end

  // Main and skid registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_rd    <= '0;
      r_m_we    <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_rd    <= '0;
      r_s_we    <= 1'b0;
    end else begin
      r_m_valid <= w_m_valid_nx;
      r_m_data  <= w_m_data_nx;
      r_m_rd    <= w_m_rd_nx;
      r_m_we    <= w_m_we_nx;
      r_s_valid <= w_s_valid_nx;
      r_s_data  <= w_s_data_nx;
      r_s_rd    <= w_s_rd_nx;
      r_s_we    <= w_s_we_nx;
    end
  end

  // Redirect fires on acceptance regardless of downstream backpressure; target holds otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_misalign    <= 1'b0;
    end else if (w_accept && w_taken) begin
      r_redir_valid <= 1'b1;
      r_redir_pc    <= w_target;
      r_misalign    <= w_target[1];
    end else begin
      r_redir_valid <= 1'b0;
    end
  end

  assign bus.in_ready_o       = ~r_s_valid;
  assign bus.out_valid_o      = r_m_valid;
  assign bus.out_data_o       = r_m_data;
  assign bus.out_rd_o         = r_m_rd;
  assign bus.out_we_o         = r_m_we;
  assign bus.redirect_valid_o = r_redir_valid;
  assign bus.redirect_pc_o    = r_redir_pc;
  assign bus.misalign_o       = r_misalign;

endmodule
